systolic_bit_loader: RTL
========================

# systolic_bit_loader

Upstream feeder for `systolic_4x4`. It accepts one frame of parallel operands over a valid/ready port: four weight sets followed by four input sets, each set being four 4-bit elements. After the frame is in, it issues a one-cycle `start` pulse and then streams every set bit-serially, LSB first, on the array's `bit_inputs` lane bus. It then waits for the array's `valid_out` and reports frame completion, or a timeout if the array never responds.

## Interface
Parameters:
- `LANES`, 4: parallel bit lanes, equal to the array row count.
- `BITS`, 4: bits per element, streamed LSB first.
- `SETS`, 4: weight sets per frame; the frame also carries the same number of input sets.
- `TIMEOUT`, 64: maximum cycles in WAIT before an error is raised.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  LANES*BITS  one set; element i in `[BITS*i+BITS-1 : BITS*i]`.
- `start`  out  1  one-cycle frame-start pulse to the array.
- `bit_inputs`  out  LANES  lane i carries bit k of element i on shift cycle k of a set.
- `array_valid`  in  1  the array's `valid_out`.
- `busy`  out  1  high whenever state is not LOAD.
- `frame_done`  out  1  one-cycle pulse when the array responded.
- `timeout_err`  out  1  one-cycle pulse when WAIT expired.

## Operation
- The frame buffer holds 2*SETS words of LANES*BITS bits each. Words 0..SETS-1 are weights; words SETS..2*SETS-1 are inputs.
- FSM states and transitions:
  - LOAD: `in_ready`=1. Each accepted word (`in_valid && in_ready`) is written at `wr_cnt`, and `wr_cnt` increments. Acceptance of word 2*SETS-1 moves to START.
  - START: `start`=1 for exactly one cycle, then go to SHIFT.
  - SHIFT: runs 2*SETS*BITS cycles (32 by default). Cycle c drives set `c / BITS`, bit `c % BITS`. `bit_inputs[i]` = `buf[c/BITS][BITS*i + c%BITS]`. After the final cycle, go to WAIT.
  - WAIT: counts cycles.
    - `array_valid`=1 → pulse `frame_done`, go to LOAD.
    - Otherwise, after TIMEOUT cycles without `array_valid` → pulse `timeout_err`, go to LOAD.
    - If `array_valid` arrives on the timeout cycle, it wins: `frame_done` pulses and `timeout_err` does not.
- `array_valid` is ignored outside WAIT, including any stale assertion during START or SHIFT.
- `bit_inputs` = 0 in every state except SHIFT.
- All outputs are registered. No back-pressure from the array; the stream is never stalled once started.
- Counters:
  - `wr_cnt` spans 0..2*SETS.
  - `sh_cnt` spans 0..2*SETS*BITS-1.
  - `to_cnt` spans 0..TIMEOUT.
  - All counters clear on entry to their state. There is no wrap-around beyond terminal counts.
- Reset at any point (mid-load, mid-shift, mid-wait):
  - Next state is LOAD and all counters clear.
  - The buffer contents are don't-care; a partial frame is discarded.
  - No `start`, `frame_done` or `timeout_err` is issued.

## Timing
- Reset values: `in_ready`=1 the cycle after reset deasserts, and 0 while reset is high. `start`, `bit_inputs`, `busy`, `frame_done` and `timeout_err` are all 0.
- Last word accepted at edge N:
  - Cycle N+1 (START): `start`=1 and `in_ready`=0.
  - Cycles N+2..N+33 (SHIFT): `bit_inputs` valid. The first bit appears the cycle immediately after `start`.
  - From N+34: WAIT.
- `array_valid` sampled high at edge M in WAIT → `frame_done`=1 in cycle M+1. In that same cycle the state is LOAD and `in_ready`=1.
- Minimum frame period: 8 load cycles + 1 + 32 + at least 1 wait cycle.
- `in_valid` held high in LOAD with no gaps loads 8 words in 8 cycles. Gaps in `in_valid` simply stall `wr_cnt`.

## Test plan
- **Serialization.** Frame with word0=16'h4321, words 1..3 = 16'h8765, 16'hCBA9, 16'h0FED, and inputs 16'h1111, 16'h2222, 16'h3333, 16'h4444.
  - `start` pulses once.
  - `bit_inputs` for the first four SHIFT cycles = 4'b0101, 4'b0110, 4'b1000, 4'b0000.
  - Input set 0 gives 4'b1111, 4'b0000, 4'b0000, 4'b0000.
  - Exactly 32 SHIFT cycles, then `bit_inputs`=0.
- **Handshake gaps.** `in_valid` toggling 1,0,1,0…
  - Exactly 8 acceptances are recorded.
  - `start` arrives one cycle after the 8th acceptance.
  - `in_ready`=0 from START until `frame_done`.
- **Completion.** `array_valid` pulsed 5 cycles into WAIT, after a stale pulse during SHIFT.
  - The SHIFT pulse is ignored.
  - `frame_done` fires once, one cycle after the WAIT pulse.
  - `busy` falls in the same cycle; `timeout_err` stays 0.
- **Timeout.** `array_valid` never asserted.
  - `timeout_err` pulses TIMEOUT (64) cycles after entering WAIT.
  - `frame_done` stays 0; the loader returns to LOAD.
- **Coincident response.** `array_valid` on the timeout cycle → `frame_done`=1 and `timeout_err`=0.
- **Reset mid-operation.** Reset asserted during SHIFT cycle 10, then a fresh frame is loaded.
  - All outputs are 0 the next cycle.
  - The new frame streams its own bits with no residue from the aborted frame.

Source files
------------

// File: rtl/systolic_bit_loader.sv
// rtl/systolic_bit_loader.sv - frame loader that streams operand sets bit-serially into systolic_4x4
// Collects 2*SETS parallel words, pulses start, shifts every set LSB first, then waits for the array.
module systolic_bit_loader #(
  parameter int LANES   = 4,
  parameter int BITS    = 4,
  parameter int SETS    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*BITS-1:0] in_data,
  output logic                  start,
  output logic [LANES-1:0]      bit_inputs,
  input  logic                  array_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err
);

  localparam int WORDS  = 2 * SETS;
  localparam int SHIFTS = WORDS * BITS;
  localparam int WR_W   = $clog2(WORDS + 1);
  localparam int ADDR_W = $clog2(WORDS);
  localparam int SH_W   = $clog2(SHIFTS);
  localparam int BIT_W  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_SHIFT, S_WAIT} state_t;

  state_t                  state, state_n;
  logic [WR_W-1:0]         wr_cnt, wr_cnt_n;
  logic [SH_W-1:0]         sh_cnt, sh_cnt_n;
  logic [TO_W-1:0]         to_cnt, to_cnt_n;
  logic                    start_n, frame_done_n, timeout_err_n;
  logic [LANES-1:0]        bits_n, lane_bits;
  logic [LANES*BITS-1:0]   frame_buf [WORDS];
  logic [SH_W-1:0]         sh_idx;
  logic [ADDR_W-1:0]       set_sel;
  logic [BIT_W-1:0]        bit_sel;
  logic [BITS-1:0]         elem;
  logic                    accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      frame_buf[wr_cnt[ADDR_W-1:0]] <= in_data;
    end
  end

  // Bits are registered, so the mux looks one shift position ahead of sh_cnt.
  always_comb begin
    sh_idx = '0;
    if (state == S_SHIFT) begin
      sh_idx = sh_cnt + 1'b1;
    end
  end

  assign set_sel = ADDR_W'(sh_idx / SH_W'(BITS));
  assign bit_sel = BIT_W'(sh_idx % SH_W'(BITS));

  always_comb begin
    lane_bits = '0;
    elem      = '0;
    for (int i = 0; i < LANES; i++) begin
      elem         = frame_buf[set_sel][BITS*i +: BITS];
      lane_bits[i] = elem[bit_sel];
    end
  end

  always_comb begin
    state_n       = state;
    wr_cnt_n      = wr_cnt;
    sh_cnt_n      = sh_cnt;
    to_cnt_n      = to_cnt;
    start_n       = 1'b0;
    bits_n        = '0;
    frame_done_n  = 1'b0;
    timeout_err_n = 1'b0;
    case (state)
      S_LOAD: begin
        if (accept) begin
          wr_cnt_n = wr_cnt + 1'b1;
          if (wr_cnt == WR_W'(WORDS - 1)) begin
            state_n = S_START;
            start_n = 1'b1;
          end
        end
      end
      S_START: begin
        state_n  = S_SHIFT;
        sh_cnt_n = '0;
        bits_n   = lane_bits;
      end
      S_SHIFT: begin
        if (sh_cnt == SH_W'(SHIFTS - 1)) begin
          state_n  = S_WAIT;
          to_cnt_n = '0;
        end else begin
          sh_cnt_n = sh_cnt + 1'b1;
          bits_n   = lane_bits;
        end
      end
      S_WAIT: begin
        // A response on the final wait cycle takes priority over the timeout.
        if (array_valid) begin
          state_n      = S_LOAD;
          wr_cnt_n     = '0;
          frame_done_n = 1'b1;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_n       = S_LOAD;
          wr_cnt_n      = '0;
          timeout_err_n = 1'b1;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      wr_cnt      <= '0;
      sh_cnt      <= '0;
      to_cnt      <= '0;
      in_ready    <= 1'b0;
      start       <= 1'b0;
      bit_inputs  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wr_cnt      <= wr_cnt_n;
      sh_cnt      <= sh_cnt_n;
      to_cnt      <= to_cnt_n;
      in_ready    <= (state_n == S_LOAD);
      start       <= start_n;
      bit_inputs  <= bits_n;
      busy        <= (state_n != S_LOAD);
      frame_done  <= frame_done_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule
